// File: rtl/poly_note_pkg.sv
// Shared constants and helpers for the polyphonic note player: mix width,
// saturation and the quarter-wave sine table used by every voice.
package poly_note_pkg;

  localparam int REST_NOTE  = 0;
  localparam int PHASE_W    = 12;
  localparam int WAVE_IDX_W = 6;

  // Sum width that holds NUM_VOICES full-scale samples without overflow.
  function automatic int mix_width(input int sample_w, input int num_voices);
    return sample_w + $clog2(num_voices) + 1;
  endfunction

  function automatic logic signed [31:0] saturate(input logic signed [31:0] value,
                                                  input int width);
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
    min_v = -(32'sd1 <<< (width - 1));
    if (value > max_v) return max_v;
    if (value < min_v) return min_v;
    return value;
  endfunction

  // 64-step full wave built from a 17-entry quarter table by mirroring/negating.
  function automatic logic signed [15:0] sine_lookup(input logic [WAVE_IDX_W-1:0] idx);
    logic [4:0]         q;
    logic signed [15:0] mag;
    q = idx[4] ? (5'd16 - {1'b0, idx[3:0]}) : {1'b0, idx[3:0]};
    case (q)
      5'd0:    mag = 16'sd0;
      5'd1:    mag = 16'sd3212;
      5'd2:    mag = 16'sd6393;
      5'd3:    mag = 16'sd9512;
      5'd4:    mag = 16'sd12539;
      5'd5:    mag = 16'sd15446;
      5'd6:    mag = 16'sd18204;
      5'd7:    mag = 16'sd20787;
      5'd8:    mag = 16'sd23170;
      5'd9:    mag = 16'sd25329;
      5'd10:   mag = 16'sd27245;
      5'd11:   mag = 16'sd28898;
      5'd12:   mag = 16'sd30273;
      5'd13:   mag = 16'sd31356;
      5'd14:   mag = 16'sd32137;
      5'd15:   mag = 16'sd32609;
      5'd16:   mag = 16'sd32767;
      default: mag = 16'sd0;
    endcase
    return idx[5] ? -mag : mag;
  endfunction

endpackage

// File: rtl/poly_note_player_voice.sv
// One voice of the player: note/duration registers, frequency lookup, sine
// reader and rest/inactive masking of the produced sample.
module frequency_rom
  import poly_note_pkg::*;
#(
  parameter int NOTE_W = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NOTE_W-1:0]  note,
  output logic [PHASE_W-1:0] step
);
  // Linear pitch map: phase step of 8 per note index, rest gives a frozen phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) step <= '0;
    else          step <= PHASE_W'({note, 3'b000});
  end
endmodule

module sine_reader
  import poly_note_pkg::*;
#(
  parameter int SAMPLE_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       request,
  input  logic [PHASE_W-1:0]         step,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic                       sample_ready
);
  logic [PHASE_W-1:0] phase;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase        <= '0;
      sample       <= '0;
      sample_ready <= 1'b0;
    end else begin
      sample_ready <= request;
      if (request) begin
        sample <= SAMPLE_W'(sine_lookup(phase[PHASE_W-1 -: WAVE_IDX_W]));
        phase  <= phase + step;
      end
    end
  end
endmodule

module note_voice
  import poly_note_pkg::*;
#(
  parameter int NOTE_W   = 6,
  parameter int DUR_W    = 6,
  parameter int SAMPLE_W = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       play_enable,
  input  logic                       load,
  input  logic [NOTE_W-1:0]          note_to_load,
  input  logic [DUR_W-1:0]           duration_to_load,
  input  logic                       beat,
  input  logic                       request,
  output logic                       done_with_note,
  output logic                       voice_active,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic                       sample_ready
);
  logic [NOTE_W-1:0]          note;
  logic [DUR_W-1:0]           dur_cnt;
  logic [PHASE_W-1:0]         step;
  logic signed [SAMPLE_W-1:0] raw_sample;
  logic                       sine_reset;
  logic                       tick;

  assign tick         = beat && play_enable;
  assign voice_active = (dur_cnt != '0);
  assign sine_reset   = !reset_n;

  // A load always wins over a coinciding beat; restarting never pulses done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      note           <= '0;
      dur_cnt        <= '0;
      done_with_note <= 1'b0;
    end else begin
      if (load) begin
        note    <= note_to_load;
        dur_cnt <= duration_to_load;
      end else if (tick && voice_active) begin
        dur_cnt <= dur_cnt - DUR_W'(1);
      end
      done_with_note <= load ? (duration_to_load == '0)
                             : (tick && dur_cnt == DUR_W'(1));
    end
  end

  frequency_rom #(.NOTE_W(NOTE_W)) u_rom (
    .clk     (clk),
    .reset_n (reset_n),
    .note    (note),
    .step    (step)
  );

  sine_reader #(.SAMPLE_W(SAMPLE_W)) u_sine (
    .clk          (clk),
    .reset        (sine_reset),
    .request      (request),
    .step         (step),
    .sample       (raw_sample),
    .sample_ready (sample_ready)
  );

  assign sample = (voice_active && note != NOTE_W'(REST_NOTE)) ? raw_sample : '0;
endmodule

// File: rtl/poly_note_player.sv
// Polyphonic note player: NUM_VOICES voices whose samples are collected,
// summed, scaled and saturated into one registered codec sample.
module poly_note_player
  import poly_note_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6,
  parameter int SAMPLE_W   = 16,
  parameter int MIX_SHIFT  = 2,
  localparam int SEL_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       play_enable,
  input  logic                       load_new_note,
  input  logic [SEL_W-1:0]           voice_sel,
  input  logic [NOTE_W-1:0]          note_to_load,
  input  logic [DUR_W-1:0]           duration_to_load,
  input  logic                       beat,
  input  logic                       generate_next_sample,
  output logic [NUM_VOICES-1:0]      done_with_note,
  output logic [NUM_VOICES-1:0]      voice_active,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       new_sample_ready
);
  localparam int MIX_W = mix_width(SAMPLE_W, NUM_VOICES);

  logic [NUM_VOICES-1:0]      load_vec;
  logic [NUM_VOICES-1:0]      ready;
  logic [NUM_VOICES-1:0]      pend;
  logic [NUM_VOICES-1:0]      pend_next;
  logic signed [SAMPLE_W-1:0] voice_sample [NUM_VOICES];
  logic signed [SAMPLE_W-1:0] hold         [NUM_VOICES];
  logic signed [SAMPLE_W-1:0] hold_next    [NUM_VOICES];
  logic signed [MIX_W-1:0]    mix_sum;
  logic signed [MIX_W-1:0]    mix_scaled;
  logic                       busy;
  logic                       request;
  logic                       mix_fire;

  // Requests are dropped for the whole mix so no voice is re-triggered mid-mix.
  assign request = generate_next_sample && play_enable && !busy;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    assign load_vec[v] = load_new_note && (voice_sel == SEL_W'(v));

    note_voice #(
      .NOTE_W   (NOTE_W),
      .DUR_W    (DUR_W),
      .SAMPLE_W (SAMPLE_W)
    ) u_voice (
      .clk              (clk),
      .reset_n          (reset_n),
      .play_enable      (play_enable),
      .load             (load_vec[v]),
      .note_to_load     (note_to_load),
      .duration_to_load (duration_to_load),
      .beat             (beat),
      .request          (request),
      .done_with_note   (done_with_note[v]),
      .voice_active     (voice_active[v]),
      .sample           (voice_sample[v]),
      .sample_ready     (ready[v])
    );
  end

  // Mix from the post-latch view so the result registers as the last voice lands.
  // NOTE: every combinational output is assigned a default first so no latch
  // can be inferred on any path.
  always_comb begin
    pend_next = pend | ready;
    mix_fire  = &pend_next;
    mix_sum   = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      hold_next[v] = ready[v] ? voice_sample[v] : hold[v];
      mix_sum      = mix_sum + MIX_W'(hold_next[v]);
    end
    mix_scaled = mix_sum >>> MIX_SHIFT;
  end

  // NOTE: the small hold array is reset with everything else so a mix never
  // reads undefined values after power-up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int v = 0; v < NUM_VOICES; v++) hold[v] <= '0;
      pend             <= '0;
      busy             <= 1'b0;
      sample_out       <= '0;
      new_sample_ready <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) hold[v] <= hold_next[v];
      new_sample_ready <= mix_fire;
      if (mix_fire) begin
        sample_out <= SAMPLE_W'(saturate(32'(mix_scaled), SAMPLE_W));
        pend       <= '0;
        busy       <= 1'b0;
      end else begin
        pend <= pend_next;
        if (request) busy <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_poly_note_player.sv
// Bench for poly_note_player: a cycle model built from the behavioural rules
// is compared on every cycle against a default DUT and a MIX_SHIFT=0 DUT.
module tb_poly_note_player;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        play_enable = 1'b0;
  logic        load_new_note = 1'b0;
  logic [1:0]  voice_sel = '0;
  logic [5:0]  note_to_load = '0;
  logic [5:0]  duration_to_load = '0;
  logic        beat = 1'b0;
  logic        generate_next_sample = 1'b0;

  logic [3:0]         done_a, active_a, done_b, active_b;
  logic signed [15:0] sample_a, sample_b;
  logic               nsr_a, nsr_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  poly_note_player dut_a (
    .clk(clk), .reset_n(reset_n), .play_enable(play_enable),
    .load_new_note(load_new_note), .voice_sel(voice_sel),
    .note_to_load(note_to_load), .duration_to_load(duration_to_load),
    .beat(beat), .generate_next_sample(generate_next_sample),
    .done_with_note(done_a), .voice_active(active_a),
    .sample_out(sample_a), .new_sample_ready(nsr_a)
  );

  poly_note_player #(.MIX_SHIFT(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .play_enable(play_enable),
    .load_new_note(load_new_note), .voice_sel(voice_sel),
    .note_to_load(note_to_load), .duration_to_load(duration_to_load),
    .beat(beat), .generate_next_sample(generate_next_sample),
    .done_with_note(done_b), .voice_active(active_b),
    .sample_out(sample_b), .new_sample_ready(nsr_b)
  );

  task automatic check(input string name, input int act, input int exp, input int tol = 0);
    n_tests++;
    if (act > exp + tol || act < exp - tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Ideal sine, rounded to nearest, full scale 32767, 64 steps per period.
  function automatic int wave(input int i);
    real r;
    r = 32767.0 * $sin(2.0 * 3.14159265358979 * i / 64.0);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
  endfunction

  function automatic int sat16(input int x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  // ---------------- behavioural model ----------------
  int       m_dur[4], m_note[4], m_phase[4], m_raw[4];
  bit       m_busy;
  bit [3:0] m_done;
  bit       m_nsr;
  int       m_samp_a, m_samp_b;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      for (int v = 0; v < 4; v++) begin
        m_dur[v] = 0; m_note[v] = 0; m_phase[v] = 0; m_raw[v] = 0;
      end
      m_busy = 0; m_done = '0; m_nsr = 0; m_samp_a = 0; m_samp_b = 0;
    end else begin
      bit accept;
      int sum;
      accept = generate_next_sample && play_enable && !m_busy;
      // A mix completes one edge after the request: voices sound only if
      // still active and not resting when their samples come back.
      if (m_busy) begin
        sum = 0;
        for (int v = 0; v < 4; v++)
          if (m_dur[v] != 0 && m_note[v] != 0) sum += m_raw[v];
        m_samp_a = sat16(sum >>> 2);
        m_samp_b = sat16(sum);
        m_nsr  = 1;
        m_busy = 0;
      end else begin
        m_nsr = 0;
      end
      if (accept) begin
        for (int v = 0; v < 4; v++) begin
          m_raw[v]   = wave(m_phase[v] / 64);
          m_phase[v] = (m_phase[v] + 8 * m_note[v]) % 4096;
        end
        m_busy = 1;
      end
      for (int v = 0; v < 4; v++) begin
        bit ld;
        ld = load_new_note && (int'(voice_sel) == v);
        m_done[v] = ld ? (duration_to_load == 0)
                       : (beat && play_enable && m_dur[v] == 1);
        if (ld) begin
          m_dur[v]  = int'(duration_to_load);
          m_note[v] = int'(note_to_load);
        end else if (beat && play_enable && m_dur[v] > 0) begin
          m_dur[v] = m_dur[v] - 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    bit [3:0] m_active;
    @(negedge clk);
    for (int v = 0; v < 4; v++) m_active[v] = (m_dur[v] != 0);
    check("done_a",   int'(done_a),   int'(m_done));
    check("active_a", int'(active_a), int'(m_active));
    check("nsr_a",    int'(nsr_a),    int'(m_nsr));
    check("sample_a", int'(sample_a), m_samp_a, 1);
    check("done_b",   int'(done_b),   int'(m_done));
    check("active_b", int'(active_b), int'(m_active));
    check("nsr_b",    int'(nsr_b),    int'(m_nsr));
    check("sample_b", int'(sample_b), m_samp_b, 1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v, input int n, input int d);
    load_new_note    = 1'b1;
    voice_sel        = 2'(v);
    note_to_load     = 6'(n);
    duration_to_load = 6'(d);
    tick(1);
    load_new_note = 1'b0;
  endtask

  task automatic do_beat();
    beat = 1'b1;
    tick(1);
    beat = 1'b0;
  endtask

  task automatic do_request(output int sa, output int sb, output int lat);
    bit got;
    got = 0; sa = 0; sb = 0; lat = -1;
    generate_next_sample = 1'b1;
    tick(1);
    generate_next_sample = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (nsr_a) begin
        got = 1; sa = int'(sample_a); sb = int'(sample_b); lat = i;
      end
    end
    check("mix_timeout", int'(got), 1);
    @(posedge clk); #1;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int sa, sb, lat;
    tick(3);
    @(negedge clk);
    check("reset_active", int'(active_a), 0);
    check("reset_sample", int'(sample_a), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    play_enable = 1'b1;
    tick(2);

    // Reset mid-mix: build a non-zero output first, then abort a mix.
    do_load(0, 16, 10);
    tick(3);
    do_request(sa, sb, lat);
    check("rst_req1_a", sa, 0);
    do_request(sa, sb, lat);
    check("rst_req2_a", sa, 1598);
    check("rst_req2_b", sb, 6393, 1);
    generate_next_sample = 1'b1;
    tick(1);
    generate_next_sample = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    check("midmix_sample", int'(sample_a), 0);
    check("midmix_nsr",    int'(nsr_a), 0);
    check("midmix_active", int'(active_a), 0);
    @(posedge clk); #1;
    tick(1);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("nsr_after_reset", int'(nsr_a), 0);
    end
    @(posedge clk); #1;

    // Single voice: note 10, duration 3.
    do_load(0, 10, 3);
    tick(3);
    do_request(sa, sb, lat);
    check("sv_req1_a", sa, 0);
    check("sv_latency", lat, 1);
    do_request(sa, sb, lat);
    check("sv_req2_a", sa, 803);
    check("sv_req2_b", sb, 3212);
    do_request(sa, sb, lat);
    check("sv_req3_a", sa, 1598);
    do_beat(); tick(2);
    do_beat(); tick(2);
    check("sv_active_2beats", int'(active_a), 1);
    do_beat();
    @(negedge clk);
    check("sv_done", int'(done_a), 1);
    check("sv_inactive", int'(active_a), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("sv_done_one_cycle", int'(done_a), 0);
    @(posedge clk); #1;

    // Simultaneous load (v1) and beat while v2 holds count 1.
    do_load(2, 0, 2);
    tick(2);
    do_beat(); tick(2);
    beat = 1'b1;
    do_load(1, 0, 5);
    beat = 1'b0;
    @(negedge clk);
    check("sim_done", int'(done_a), 4'b0100);
    check("sim_active", int'(active_a), 4'b0010);
    @(posedge clk); #1;
    tick(1);
    repeat (4) begin do_beat(); tick(2); end
    do_beat();
    @(negedge clk);
    check("sim_v1_done", int'(done_a), 4'b0010);
    @(posedge clk); #1;
    tick(1);

    // Rest note with duration 4, then zero-duration load.
    do_load(3, 0, 4);
    tick(3);
    do_request(sa, sb, lat);
    check("rest_sample", sa, 0);
    check("rest_active", int'(active_a), 4'b1000);
    repeat (3) begin do_beat(); tick(2); end
    check("rest_active_3beats", int'(active_a), 4'b1000);
    do_beat();
    @(negedge clk);
    check("rest_done", int'(done_a), 4'b1000);
    @(posedge clk); #1;
    tick(2);
    do_load(3, 7, 0);
    @(negedge clk);
    check("zero_dur_done", int'(done_a), 4'b1000);
    check("zero_dur_active", int'(active_a), 0);
    @(posedge clk); #1;
    tick(2);

    // Pause: frozen countdown and gated requests, then resume.
    do_load(0, 5, 6);
    tick(3);
    do_beat(); tick(2);
    play_enable = 1'b0;
    repeat (5) begin
      beat = 1'b1; generate_next_sample = 1'b1;
      tick(1);
      beat = 1'b0; generate_next_sample = 1'b0;
      tick(3);
    end
    check("pause_active", int'(active_a), 1);
    play_enable = 1'b1;
    tick(1);
    do_request(sa, sb, lat);
    repeat (4) begin do_beat(); tick(2); end
    do_beat();
    @(negedge clk);
    check("resume_done", int'(done_a), 1);
    @(posedge clk); #1;

    // Saturation: four voices in phase on note 32.
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    for (int v = 0; v < 4; v++) do_load(v, 32, 60);
    tick(3);
    for (int k = 1; k <= 12; k++) begin
      do_request(sa, sb, lat);
      if (k == 2) begin
        check("sat_pos_b", sb, 32767);
        check("sat_pos_a", sa, 12539, 1);
      end
      if (k == 11) begin
        check("sat_neg_b", sb, -32768);
        check("sat_neg_a", sa, -23170, 1);
      end
    end

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
